// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready stage handshake bundle carrying pc, bd, exc, payload and bubble flag
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);
  logic              valid;
  logic              ready;
  logic              bubble;
  logic [PC_W-1:0]   pc;
  logic              bd;
  logic [EXC_W-1:0]  exc;
  logic [DATA_W-1:0] data;

  // Producer side: drives the entry, observes ready.
  modport master (output valid, bubble, pc, bd, exc, data, input ready);

  // Consumer side: bubble is produced only by the stage itself, so it is not consumed here.
  modport slave  (input valid, pc, bd, exc, data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised MIPS inter-stage register with flush/req bubbles; PIPE_SKID_EN adds a two-entry skid buffer
module pipe_stage_reg #(
  parameter int              DATA_W = 128,
  parameter int              PC_W   = 32,
  parameter int              EXC_W  = 5,
  parameter logic [PC_W-1:0] EXC_PC = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req,
  pipe_stage_reg_if.slave  in_bus,
  pipe_stage_reg_if.master out_bus
);

  typedef struct packed {
    logic              valid;
    logic              bubble;
    logic [PC_W-1:0]   pc;
    logic              bd;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
  } entry_t;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, HEAD = 2'd1, FULL = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, HEAD = 1'b1} state_t;
`endif

  state_t state_q, state_d;
  entry_t main_q, main_d;
`ifdef PIPE_SKID_EN
  entry_t skid_q, skid_d;
`endif

  entry_t in_entry;
  logic   in_ready;
  logic   accept;
  logic   pop;

  assign in_entry = '{valid: 1'b1, bubble: 1'b0, pc: in_bus.pc, bd: in_bus.bd,
                      exc: in_bus.exc, data: in_bus.data};

  // With the skid buffer, ready depends only on held occupancy (never on out_ready);
  // without it, the single register can refill in the same cycle it drains.
`ifdef PIPE_SKID_EN
  assign in_ready = (state_q != FULL) & ~flush & ~req;
`else
  assign in_ready = (~main_q.valid | out_bus.ready) & ~flush & ~req;
`endif

  assign accept       = in_bus.valid & in_ready;
  assign pop          = main_q.valid & out_bus.ready;
  assign in_bus.ready = in_ready;

  assign out_bus.valid  = main_q.valid;
  assign out_bus.bubble = main_q.bubble;
  assign out_bus.pc     = main_q.pc;
  assign out_bus.bd     = main_q.bd;
  assign out_bus.exc    = main_q.exc;
  assign out_bus.data   = main_q.data;

  // Next occupancy and entry contents: req beats flush beats normal FIFO movement.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (req) begin
      main_d  = '{valid: 1'b1, bubble: 1'b1, pc: EXC_PC, bd: 1'b0, exc: '0, data: '0};
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
      state_d = HEAD;
    end else if (flush) begin
      // Bubble keeps the upstream PC/BD so CP0 still sees the architectural position.
      main_d  = '{valid: 1'b1, bubble: 1'b1, pc: in_bus.pc, bd: in_bus.bd, exc: '0, data: '0};
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
      state_d = HEAD;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = HEAD;
          end
        end
        HEAD: begin
          if (accept && pop) begin
            main_d = in_entry;
`ifdef PIPE_SKID_EN
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
`endif
          end else if (pop) begin
            main_d  = '0;
            state_d = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = HEAD;
          end
        end
`endif
        default: begin
          main_d  = '0;
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; async reset clears every field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef PIPE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (vector table, directed corners, random vs queue model)
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic req;

  pipe_stage_reg_if #(.DATA_W(128), .PC_W(32), .EXC_W(5)) in_bus ();
  pipe_stage_reg_if #(.DATA_W(128), .PC_W(32), .EXC_W(5)) out_bus ();

  assign in_bus.bubble = 1'b0;

  pipe_stage_reg #(.DATA_W(128), .PC_W(32), .EXC_W(5), .EXC_PC(EXC_PC)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .flush   (flush),
    .req     (req),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
    logic [127:0] data;
    logic         bub;
  } ment_t;

  ment_t mq[$];
  bit    m_accept;
  bit    m_pop;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic r, input logic v, input logic [31:0] pc,
                       input logic bd, input logic [4:0] exc, input logic [127:0] data,
                       input logic ordy);
    flush          = f;
    req            = r;
    in_bus.valid   = v;
    in_bus.pc      = pc;
    in_bus.bd      = bd;
    in_bus.exc     = exc;
    in_bus.data    = data;
    out_bus.ready  = ordy;
  endtask

  // Reference: a FIFO of capacity CAP; flush/req replace its contents by one bubble.
  task automatic model_check();
    bit rdy;
    if (CAP == 2) rdy = (mq.size() < 2);
    else          rdy = (mq.size() == 0) || out_bus.ready;
    rdy      = rdy && !flush && !req;
    m_accept = in_bus.valid && rdy;
    m_pop    = (mq.size() > 0) && out_bus.ready;
    chk("m_in_ready", in_bus.ready, rdy);
    chk("m_out_valid", out_bus.valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_out_pc", out_bus.pc, mq[0].pc);
      chk("m_out_bd", out_bus.bd, mq[0].bd);
      chk("m_out_exc", out_bus.exc, mq[0].exc);
      chk("m_out_data", out_bus.data, mq[0].data);
      chk("m_out_bubble", out_bus.bubble, mq[0].bub);
    end
  endtask

  task automatic model_update();
    ment_t e;
    if (req) begin
      mq.delete();
      e = '{pc: EXC_PC, bd: 1'b0, exc: 5'd0, data: 128'd0, bub: 1'b1};
      mq.push_back(e);
    end else if (flush) begin
      mq.delete();
      e = '{pc: in_bus.pc, bd: in_bus.bd, exc: 5'd0, data: 128'd0, bub: 1'b1};
      mq.push_back(e);
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_accept) begin
        e = '{pc: in_bus.pc, bd: in_bus.bd, exc: in_bus.exc, data: in_bus.data, bub: 1'b0};
        mq.push_back(e);
      end
    end
  endtask

  // Entered at a negedge with inputs already driven; leaves at the next negedge.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic         f, r, v;
    logic [31:0]  pc;
    logic         bd;
    logic [127:0] data;
    logic         e_rdy, e_valid;
    logic [31:0]  e_pc;
    logic         e_bd, e_bub;
    logic [127:0] e_data;
  } vec_t;

  vec_t vt[9];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 128'd0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_bus.valid, 1'b0);
    chk("rst_out_bubble", out_bus.bubble, 1'b0);
    chk("rst_out_pc", out_bus.pc, 32'd0);
    chk("rst_out_data", out_bus.data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_bus.ready, 1'b1);
    chk("rel_out_valid", out_bus.valid, 1'b0);
    @(negedge clk);

    // Streaming, flush and req with out_ready held high: identical in both builds.
    //        f     r     v     pc            bd    data         rdy   val   e_pc          bd    bub   e_data
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 128'hA0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 128'hA0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h3004, 1'b0, 128'hA1, 1'b1, 1'b1, 32'h3004, 1'b0, 1'b0, 128'hA1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h3008, 1'b1, 128'hA2, 1'b1, 1'b1, 32'h3008, 1'b1, 1'b0, 128'hA2};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0000, 1'b0, 128'h00, 1'b1, 1'b0, 32'h0000, 1'b0, 1'b0, 128'h00};
    vt[4] = '{1'b0, 1'b0, 1'b1, 32'h3010, 1'b0, 128'hA4, 1'b1, 1'b1, 32'h3010, 1'b0, 1'b0, 128'hA4};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h3014, 1'b1, 128'hA5, 1'b0, 1'b1, 32'h3014, 1'b1, 1'b1, 128'h00};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h3014, 1'b1, 128'hA5, 1'b1, 1'b1, 32'h3014, 1'b1, 1'b0, 128'hA5};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h3018, 1'b0, 128'hA7, 1'b0, 1'b1, EXC_PC,   1'b0, 1'b1, 128'h00};
    vt[8] = '{1'b0, 1'b0, 1'b0, 32'h0000, 1'b0, 128'h00, 1'b1, 1'b0, 32'h0000, 1'b0, 1'b0, 128'h00};

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].f, vt[i].r, vt[i].v, vt[i].pc, vt[i].bd, 5'd0, vt[i].data, 1'b1);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_bus.ready, vt[i].e_rdy);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_bus.valid, vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_out_pc", i), out_bus.pc, vt[i].e_pc);
        chk($sformatf("vec%0d_out_bd", i), out_bus.bd, vt[i].e_bd);
        chk($sformatf("vec%0d_out_bubble", i), out_bus.bubble, vt[i].e_bub);
        chk($sformatf("vec%0d_out_data", i), out_bus.data, vt[i].e_data);
      end
    end

`ifdef PIPE_SKID_EN
    // Backpressure fills both entries, then drains in order.
    drive(1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 5'd0, 128'hB0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h3004, 1'b0, 5'd0, 128'hB1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b0);
    #1;
    chk("bp_full_in_ready", in_bus.ready, 1'b0);
    chk("bp_head_pc", out_bus.pc, 32'h3000);
    out_bus.ready = 1'b1;
    #1;
    chk("bp_ready_not_comb", in_bus.ready, 1'b0);
    tick();
    chk("bp_second_pc", out_bus.pc, 32'h3004);
    chk("bp_ready_after_pop", in_bus.ready, 1'b1);
    tick();
    chk("bp_drained", out_bus.valid, 1'b0);

    // req together with flush while full: one exception bubble, skid gone.
    drive(1'b0, 1'b0, 1'b1, 32'h3020, 1'b0, 5'd0, 128'hC0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h3024, 1'b0, 5'd0, 128'hC1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h3028, 1'b1, 5'd0, 128'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b0);
    #1;
    chk("req_pc", out_bus.pc, EXC_PC);
    chk("req_bubble", out_bus.bubble, 1'b1);
    chk("req_bd", out_bus.bd, 1'b0);
    chk("req_in_ready", in_bus.ready, 1'b1);
    out_bus.ready = 1'b1;
    tick();
    chk("req_skid_empty", out_bus.valid, 1'b0);
`else
    // Single register: ready follows out_ready combinationally.
    drive(1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 5'd0, 128'hB0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h3004, 1'b0, 5'd0, 128'hB1, 1'b0);
    #1;
    chk("bp_in_ready_low", in_bus.ready, 1'b0);
    chk("bp_head_pc", out_bus.pc, 32'h3000);
    out_bus.ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_bus.ready, 1'b1);
    tick();
    chk("bp_second_pc", out_bus.pc, 32'h3004);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b1); tick();
    chk("bp_drained", out_bus.valid, 1'b0);

    drive(1'b0, 1'b0, 1'b1, 32'h3020, 1'b0, 5'd0, 128'hC0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 32'h3024, 1'b1, 5'd0, 128'hC1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b0);
    #1;
    chk("req_pc", out_bus.pc, EXC_PC);
    chk("req_bubble", out_bus.bubble, 1'b1);
    chk("req_bd", out_bus.bd, 1'b0);
    chk("req_in_ready_held", in_bus.ready, 1'b0);
    out_bus.ready = 1'b1;
    #1;
    chk("req_in_ready_comb", in_bus.ready, 1'b1);
    tick();
    chk("req_drained", out_bus.valid, 1'b0);
`endif

    // Randomised traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 16) == 0, ($urandom % 32) == 0, 1'($urandom % 2),
            {$urandom_range(0, 16383), 2'b00}, 1'($urandom % 2), 5'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, ($urandom % 4) != 0);
      tick();
    end

    // Asynchronous reset mid-stream with entries held.
    drive(1'b0, 1'b0, 1'b1, 32'h3040, 1'b1, 5'h7, 128'hD0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h3044, 1'b0, 5'h3, 128'hD1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b0);
    #2;
    chk("pre_rst_valid", out_bus.valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_bus.valid, 1'b0);
    chk("arst_out_bubble", out_bus.bubble, 1'b0);
    chk("arst_out_pc", out_bus.pc, 32'd0);
    chk("arst_out_bd", out_bus.bd, 1'b0);
    chk("arst_out_exc", out_bus.exc, 5'd0);
    chk("arst_out_data", out_bus.data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    #1;
    chk("arst_rel_in_ready", in_bus.ready, 1'b1);
    chk("arst_rel_out_valid", out_bus.valid, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h3050, 1'b0, 5'd0, 128'hE0, 1'b1); tick();
    chk("post_rst_pc", out_bus.pc, 32'h3050);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage MIPS core. Intended to replace the fixed-width hand-written stage registers (F/D, D/E, E/M, M/W).
- Carries an opaque payload plus the PC, exception-code and branch-delay fields through a valid/ready handshake.
- Supports bubble insertion (flush) and exception-entry redirect (req).
- An optional two-entry skid buffer breaks the combinational ready path between stages.

Parameters:
- DATA_W, 128: width of the opaque payload (instr, operands, A3, imm packed by the instantiating stage).
- PC_W, 32: PC width.
- EXC_W, 5: exception-code width.
- EXC_PC, 32'h0000_4180: PC loaded into the stage on req (exception handler entry).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- flush  in  1  insert bubble this cycle (stall-induced NOP).
- req  in  1  exception/interrupt taken; kill stage contents, redirect PC.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_pc  in  PC_W  upstream PC.
- in_bd  in  1  upstream branch-delay flag.
- in_exc  in  EXC_W  upstream exception code.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_pc  out  PC_W  head PC.
- out_bd  out  1  head BD flag.
- out_exc  out  EXC_W  head exception code.
- out_data  out  DATA_W  head payload.
- out_bubble  out  1  head is an inserted bubble (payload and exc are zero).

Behaviour:
- Storage: main register (head) plus skid register, each holding {valid, bubble, pc, bd, exc, data}.
- Reset (reset=0, async): both entries invalid and all fields zero. out_valid=0, out_bubble=0, out_pc=0, out_bd=0, out_exc=0, out_data=0. in_ready=1 once reset is released.
- State machine (encodes occupancy):
  - EMPTY: no entry held.
  - HEAD: main valid, skid empty.
  - FULL: both valid.
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions (no flush/req):
  - EMPTY: accept -> HEAD.
  - HEAD: accept & !pop -> FULL (input goes to skid); accept & pop -> HEAD (input goes to main); !accept & pop -> EMPTY.
  - FULL: pop -> HEAD (skid moves to main); no accept is possible in FULL.
- in_ready is registered: in_ready = (state != FULL). There is no combinational path from out_ready to in_ready.
- Order is strict FIFO; latency is 1 cycle from accept to out_valid when the stage was EMPTY.
- Priority: reset > req > flush > normal.
- req=1 at an edge:
  - Skid cleared; main becomes a bubble: valid=1, bubble=1, pc=EXC_PC, bd=0, exc=0, data=0.
  - State -> HEAD. Any concurrent accept is discarded.
- flush=1 (req=0) at an edge:
  - Skid cleared; main becomes a bubble with pc=in_pc, bd=in_bd, exc=0, data=0, so the macroscopic PC/BD is preserved for CP0.
  - State -> HEAD. The upstream entry is not consumed: in_ready is 0 during a flush cycle.
- Bubbles are ordinary entries for handshake purposes and pop normally.
- A simultaneous pop with flush/req is honoured downstream (the head was presented); the stage still loads the bubble.

Optional Feature:
- PIPE_SKID_EN
  - Defined: two-entry skid buffer as above; in_ready registered.
  - Undefined: skid register and FULL state are not built; in_ready = (!out_valid | out_ready) & !flush & !req (combinational). Otherwise HEAD/EMPTY behaviour, priorities and bubble contents are identical.

Test Plan:
- Reset: hold reset=0 mid-stream with 2 entries held -> all outputs 0 immediately (async); after release in_ready=1 and out_valid=0.
- Streaming: out_ready=1, push PCs 0x3000, 0x3004, 0x3008 on consecutive cycles -> same PCs appear one cycle later, one per cycle, data intact, out_bubble=0.
- Backpressure: out_ready=0, push 0x3000 then 0x3004 -> state FULL, in_ready=0. Raise out_ready -> 0x3000 then 0x3004 pop in order, no loss or duplication, in_ready=1 after first pop (PIPE_SKID_EN defined).
- Flush: head=0x3010, in_pc=0x3014, in_bd=1, flush=1 -> next cycle out_valid=1, out_bubble=1, out_pc=0x3014, out_bd=1, out_exc=0, out_data=0; upstream 0x3014 still offered.
- Req: FULL with 0x3020/0x3024, req=1 and flush=1 together -> single bubble with out_pc=0x4180, out_bd=0; skid empty; in_ready=1 the following cycle.
- Macro off: repeat the backpressure test without PIPE_SKID_EN -> in_ready follows out_ready combinationally; never more than one entry held.
